// File: rtl/vae_fwd_sched.sv
// Control sequencer for a small VAE forward pass: encoder MACs, reparameterisation
// sampling and decoder MACs on one shared MAC. Optional VAE_SCHED_CYCCNT_EN adds pass_cycles.
module vae_fwd_sched #(
  parameter int N_IN  = 9,
  parameter int N_LAT = 2,
  parameter int N_OUT = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic [1:0]  phase,
  output logic [3:0]  neuron_idx,
  output logic [3:0]  tap_idx,
  output logic        mac_clr,
  output logic        mac_en,
  output logic        res_we,
  output logic        rng_en
`ifdef VAE_SCHED_CYCCNT_EN
  ,
  output logic [15:0] pass_cycles
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENC    = 3'd1;
  localparam logic [2:0] S_ENC_WB = 3'd2;
  localparam logic [2:0] S_SAMP   = 3'd3;
  localparam logic [2:0] S_DEC    = 3'd4;
  localparam logic [2:0] S_DEC_WB = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] ENC_LAST_TAP = 4'(N_IN - 1);
  localparam logic [3:0] ENC_LAST_NRN = 4'(2 * N_LAT - 1);
  localparam logic [3:0] LAT_LAST     = 4'(N_LAT - 1);
  localparam logic [3:0] OUT_LAST     = 4'(N_OUT - 1);

  logic [2:0] st_q, st_d;
  logic [3:0] nrn_q, nrn_d;
  logic [3:0] tap_q, tap_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] phase_q, phase_d;
  logic       mac_clr_q, mac_clr_d;
  logic       mac_en_q, mac_en_d;
  logic       res_we_q, res_we_d;
  logic       rng_en_q, rng_en_d;

  // The registered state is the step currently presented; a stalled edge
  // re-presents the same step with its strobes suppressed.
  always_comb begin
    st_d  = st_q;
    nrn_d = nrn_q;
    tap_d = tap_q;
    if (!stall) begin
      case (st_q)
        S_IDLE: begin
          if (start) begin
            st_d  = S_ENC;
            nrn_d = 4'd0;
            tap_d = 4'd0;
          end
        end
        S_ENC: begin
          if (tap_q == ENC_LAST_TAP) st_d = S_ENC_WB;
          else                       tap_d = tap_q + 4'd1;
        end
        S_ENC_WB: begin
          tap_d = 4'd0;
          if (nrn_q == ENC_LAST_NRN) begin
            st_d  = S_SAMP;
            nrn_d = 4'd0;
          end else begin
            st_d  = S_ENC;
            nrn_d = nrn_q + 4'd1;
          end
        end
        S_SAMP: begin
          if (nrn_q == LAT_LAST) begin
            st_d  = S_DEC;
            nrn_d = 4'd0;
            tap_d = 4'd0;
          end else begin
            nrn_d = nrn_q + 4'd1;
          end
        end
        S_DEC: begin
          if (tap_q == LAT_LAST) st_d = S_DEC_WB;
          else                   tap_d = tap_q + 4'd1;
        end
        S_DEC_WB: begin
          tap_d = 4'd0;
          if (nrn_q == OUT_LAST) begin
            st_d  = S_DONE;
            nrn_d = 4'd0;
          end else begin
            st_d  = S_DEC;
            nrn_d = nrn_q + 4'd1;
          end
        end
        S_DONE: begin
          st_d  = S_IDLE;
          nrn_d = 4'd0;
          tap_d = 4'd0;
        end
        default: begin
          st_d  = S_IDLE;
          nrn_d = 4'd0;
          tap_d = 4'd0;
        end
      endcase
    end
  end

  // Output decode is taken from the next step so every output is a flop.
  always_comb begin
    busy_d    = (st_d != S_IDLE);
    phase_d   = 2'd0;
    case (st_d)
      S_ENC, S_ENC_WB: phase_d = 2'd1;
      S_SAMP:          phase_d = 2'd2;
      S_DEC, S_DEC_WB: phase_d = 2'd3;
      default:         phase_d = 2'd0;
    endcase
    mac_en_d  = !stall && ((st_d == S_ENC) || (st_d == S_DEC));
    mac_clr_d = mac_en_d && (tap_d == 4'd0);
    res_we_d  = !stall && ((st_d == S_ENC_WB) || (st_d == S_SAMP) || (st_d == S_DEC_WB));
    rng_en_d  = !stall && (st_d == S_SAMP);
    done_d    = !stall && (st_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_IDLE;
      nrn_q     <= 4'd0;
      tap_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= 2'd0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      res_we_q  <= 1'b0;
      rng_en_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      nrn_q     <= nrn_d;
      tap_q     <= tap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      phase_q   <= phase_d;
      mac_clr_q <= mac_clr_d;
      mac_en_q  <= mac_en_d;
      res_we_q  <= res_we_d;
      rng_en_q  <= rng_en_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = phase_q;
  assign neuron_idx = nrn_q;
  assign tap_idx    = tap_q;
  assign mac_clr    = mac_clr_q;
  assign mac_en     = mac_en_q;
  assign res_we     = res_we_q;
  assign rng_en     = rng_en_q;

`ifdef VAE_SCHED_CYCCNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;

  // cnt tracks the 1-based cycle index within the pass, so the value latched
  // with done is the index of the done cycle itself.
  always_comb begin
    cnt_d = cnt_q;
    pc_d  = pc_q;
    if (st_q == S_IDLE) begin
      if (st_d == S_ENC) cnt_d = 16'd1;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (done_d) pc_d = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      pc_q  <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

  assign pass_cycles = pc_q;
`endif

endmodule

// File: doc/vae_fwd_sched.md
VAE_FWD_SCHED -- requirements
Module: vae_fwd_sched

Interface
REQ-001 SHALL have parameter N_IN, default 9, meaning encoder input taps per neuron (legal 1..15).
REQ-002 SHALL have parameter N_LAT, default 2, meaning latent count; there are 2*N_LAT encoder neurons (legal 1..7).
REQ-003 SHALL have parameter N_OUT, default 9, meaning decoder neurons (legal 1..15).
REQ-004 SHALL have port clk, input, 1, meaning the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, meaning request one forward pass.
REQ-007 SHALL have port stall, input, 1, meaning the shared MAC or result store is not ready; the sequence holds.
REQ-008 SHALL have port busy, output, 1, meaning a pass is in progress (any state other than IDLE).
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse at the end of a pass.
REQ-010 SHALL have port phase, output, 2, meaning 0 IDLE/DONE, 1 encoder, 2 sample, 3 decoder.
REQ-011 SHALL have port neuron_idx, output, 4, meaning the current neuron; encoder idx 2k is mean c(k+1), idx 2k+1 is deviation d(k+1).
REQ-012 SHALL have port tap_idx, output, 4, meaning the current input/weight tap.
REQ-013 SHALL have port mac_clr, output, 1, meaning load the accumulator with bias instead of accumulating.
REQ-014 SHALL have ports mac_en, res_we and rng_en, each output, 1, meaning accumulate enable, neuron result write and RNG advance respectively.

Function
REQ-015 SHALL implement the states IDLE, ENC, ENC_WB, SAMP, DEC, DEC_WB and DONE.
REQ-016 In IDLE, start=1 SHALL move to ENC with neuron_idx=0 and tap_idx=0; start in any other state is ignored.
REQ-017 ENC SHALL assert mac_en for each tap 0..N_IN-1, with mac_clr=1 on tap 0 only, then go to ENC_WB.
REQ-018 ENC_WB SHALL assert res_we for one cycle, then go to ENC with the next neuron, or to SAMP after neuron 2*N_LAT-1.
REQ-019 SAMP SHALL last N_LAT cycles, with neuron_idx = latent 0..N_LAT-1, and rng_en and res_we each =1; this forms a = sp(d)*eps + c.
REQ-020 DEC SHALL use N_LAT taps per neuron, with mac_clr on tap 0; DEC_WB SHALL pulse res_we, then go to the next neuron, or to DONE after N_OUT-1.
REQ-021 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-022 An unstalled pass SHALL run 2*N_LAT*(N_IN+1)+N_LAT+N_OUT*(N_LAT+1)+1 cycles from the start-accepting edge to done; with defaults this is 70, and done is high in the 70th cycle.
REQ-023 While stall=1, state and counters SHALL hold and mac_en, mac_clr, res_we, rng_en and done SHALL be forced to 0.
REQ-024 When stall is deasserted, the sequence SHALL resume from the held point with no skipped or repeated taps.
REQ-025 If stall=1 in DONE, done SHALL be delayed until stall=0, and still last exactly one cycle.
REQ-026 All outputs SHALL be registered and SHALL be free of combinational paths from inputs.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, including mid-pass, and drive busy, done, phase, neuron_idx, tap_idx and all strobes to 0.
REQ-028 After rst is released, the block SHALL accept start in the first cycle.

Configuration
REQ-029 When VAE_SCHED_CYCCNT_EN is defined, the block SHALL add output pass_cycles [15:0]: the cycles counted from the start-accepting edge to done, including stall cycles.
REQ-030 With VAE_SCHED_CYCCNT_EN, pass_cycles SHALL saturate at 16'hFFFF, update on done, hold until the next done, and reset to 0.
REQ-031 Without VAE_SCHED_CYCCNT_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Defaults, start pulse, stall=0 -> done in the 70th cycle; 4+2+9 res_we pulses in total; 13 mac_clr pulses; 36+18 mac_en cycles.
REQ-033 Check the ENC neuron 1 tap sequence -> tap_idx 0..8 with mac_clr only at 0, then one res_we with neuron_idx=1.
REQ-034 stall=1 for 5 cycles at ENC tap 4 -> outputs frozen and strobes 0; done in the 75th cycle; pass_cycles=75 with the macro.
REQ-035 rst pulse at cycle 30 of a pass -> next cycle busy=0, all outputs 0; a new start gives a full 70-cycle pass.
REQ-036 start held high for 3 passes -> done pulses 71 cycles apart (70-cycle pass plus 1 cycle in IDLE); start held while busy has no effect.
REQ-037 Parameters N_IN=3, N_LAT=1, N_OUT=2 -> done in the 14th cycle (8+1+4+1).
